// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter granting NUM_REQ requesters bursts of up to BURST_LEN words on one FIFO write port.
// Optional macro FIFO_ARB_PRIO_EN gives requester 0 absolute priority at every IDLE arbitration.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  input  logic                          FULL,
  output logic                          W_INC,
  output logic [DATA_WIDTH-1:0]         WR_DATA,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [NUM_REQ-1:0]            ACK,
  output logic                          BUSY,
  output logic                          DBG_STATE
);

  localparam int            IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [3:0]    LAST_BEAT = 4'(BURST_LEN - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t               state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [3:0]           cnt_q;
  logic [IW-1:0]        last_q;

  logic [NUM_REQ-1:0]   req_m;
  logic [IW-1:0]        cand;
  logic [IW-1:0]        last_d;
  logic [NUM_REQ-1:0]   gnt_d;
  logic                 win_found;
  logic                 owner_req;
  logic                 w_inc;

  // Round-robin search begins one past the last granted index and wraps.
  always_comb begin
    req_m = REQ;
`ifdef FIFO_ARB_PRIO_EN
    req_m[0] = 1'b0;
`endif
    cand      = last_q;
    last_d    = last_q;
    win_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!win_found && req_m[cand]) begin
        win_found = 1'b1;
        last_d    = cand;
      end
    end
`ifdef FIFO_ARB_PRIO_EN
    if (REQ[0]) begin
      win_found = 1'b1;
      last_d    = '0;
    end
`endif
    gnt_d = NUM_REQ'(1) << last_d;
  end

  assign owner_req = |(REQ & gnt_q);
  assign w_inc     = (state_q == S_BURST) && owner_req && !FULL;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      last_q  <= LAST_IDX;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q <= S_BURST;
            gnt_q   <= gnt_d;
            cnt_q   <= '0;
            last_q  <= last_d;
          end
        end
        S_BURST: begin
          // A dropped request ends the burst even while FULL stalls it.
          if (!owner_req || (w_inc && (cnt_q == LAST_BEAT))) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
          end else if (w_inc) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Grant is all-zero in IDLE, so the data mux naturally yields zero there.
  always_comb begin
    WR_DATA = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) WR_DATA = WR_DATA | REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign W_INC     = w_inc;
  assign GNT       = gnt_q;
  assign ACK       = gnt_q & {NUM_REQ{w_inc}};
  assign BUSY      = (state_q == S_BURST);
  assign DBG_STATE = state_q;

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of write requesters sharing one FIFO write port.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning word width of each requester and of WR_DATA.
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning max words accepted per grant (1..15).
REQ-004 SHALL have port CLK  input  1  single clock, the FIFO write clock.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port REQ  input  NUM_REQ  per-requester request; requester i holds REQ[i] and its data until acknowledged.
REQ-007 SHALL have port REQ_DATA  input  NUM_REQ*DATA_WIDTH  flattened data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port FULL  input  1  FIFO full flag, same clock domain.
REQ-009 SHALL have port W_INC  output  1  FIFO write enable.
REQ-010 SHALL have port WR_DATA  output  DATA_WIDTH  FIFO write data.
REQ-011 SHALL have port GNT  output  NUM_REQ  registered one-hot grant, all-zero when idle.
REQ-012 SHALL have port ACK  output  NUM_REQ  one-hot pulse: word of requester i accepted this cycle.
REQ-013 SHALL have port BUSY  output  1  high while a burst is in progress.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and BURST.
REQ-015 In IDLE with any REQ high, SHALL select a winner, register GNT to its one-hot, clear the burst counter, and enter BURST next cycle; with REQ all-zero SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: search starts at the index after the last granted requester, wrapping from NUM_REQ-1 to 0.
REQ-017 In BURST, W_INC SHALL equal REQ[owner] AND NOT FULL, combinationally from the registered grant; ACK SHALL equal GNT AND W_INC.
REQ-018 WR_DATA SHALL be the owner's REQ_DATA slice in BURST and all-zero in IDLE.
REQ-019 The burst counter SHALL increment only on W_INC and SHALL hold while FULL is high.
REQ-020 BURST SHALL return to IDLE next cycle when W_INC accepts the BURST_LEN-th word or when REQ[owner] is low; GNT SHALL clear on that transition.
REQ-021 FULL high SHALL stall without releasing the grant, regardless of stall length.
REQ-022 REQ[owner] dropping while FULL is high SHALL end the burst with no write.
REQ-023 Latency SHALL be: REQ rising in IDLE -> GNT and first possible W_INC one cycle later; minimum one IDLE cycle between bursts.
REQ-024 W_INC SHALL never assert while FULL is high or in IDLE.
REQ-025 Counter width SHALL be 4 bits, compared against BURST_LEN.

Reset
REQ-026 RST high SHALL asynchronously force IDLE, GNT=0, counter=0, round-robin last-grant pointer=NUM_REQ-1 (so requester 0 searched first), BUSY=0, W_INC=0, ACK=0, WR_DATA=0.
REQ-027 RST mid-burst SHALL abort the burst immediately; words not yet acknowledged are not written.
REQ-028 After RST deasserts, arbitration SHALL start on the first CLK edge.

Configuration
REQ-029 Macro FIFO_ARB_PRIO_EN defined: requester 0 SHALL win every IDLE arbitration in which REQ[0] is high; other requesters use round-robin among themselves.
REQ-030 Macro FIFO_ARB_PRIO_EN undefined: pure round-robin over all requesters per REQ-016.
REQ-031 The macro SHALL not affect burst length, stall or reset behaviour.

Verification
REQ-032 After reset, REQ=4'b0001, FULL=0, data 0x11 -> GNT=0001 one cycle later, 4 W_INC pulses with WR_DATA=0x11, ACK[0] each, then IDLE one cycle, regrant to 0.
REQ-033 REQ=4'b1111 held, FULL=0 (no macro) -> grant order 0,1,2,3,0, each burst 4 words, one idle cycle between.
REQ-034 REQ[2] only, FULL high for cycles 2-6 of burst -> W_INC low those cycles, counter frozen, grant held, burst completes 4 words total.
REQ-035 REQ[1] drops after 2 accepted words -> exactly 2 W_INC, GNT clears next cycle, next arbitration starts at requester 2.
REQ-036 RST pulsed mid-burst after 1 word -> all outputs 0 asynchronously, next grant to requester 0 with REQ=1111.
REQ-037 FIFO_ARB_PRIO_EN defined, REQ=4'b1111 held -> requester 0 granted every burst.
